// File: rtl/multi_clock_divider.sv
// Multi-channel programmable clock-enable divider with glitch-free divisor reload.
// Build option: define DIVIDER_SQUARE_EN to generate the per-channel square-wave outputs.
module multi_clock_divider #(
    parameter int CHANNELS    = 4,
    parameter int CNT_W       = 26,
    parameter int DEFAULT_DIV = 50_000_000,
    localparam int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] enable,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CH_W-1:0]     cfg_chan,
    input  logic [CNT_W-1:0]    cfg_div,
    output logic                cfg_err,
    output logic [CHANNELS-1:0] tick,
    output logic [CHANNELS-1:0] sq_out
);

    logic [CNT_W-1:0]    cnt      [CHANNELS];
    logic [CNT_W-1:0]    div      [CHANNELS];
    logic [CNT_W-1:0]    shadow   [CHANNELS];
    logic [CNT_W-1:0]    cnt_next [CHANNELS];
    logic [CNT_W-1:0]    div_next [CHANNELS];
    logic [CHANNELS-1:0] pending;
    logic [CHANNELS-1:0] wrap;
    logic [CHANNELS-1:0] apply;
    logic                accept;
    logic                cfg_ok;

    assign accept = cfg_valid && cfg_ready;
    assign cfg_ok = (cfg_div != '0) && (int'(cfg_chan) < CHANNELS);

    // Wrap uses >= so a divisor shrunk below the held count (reload while disabled)
    // wraps on the next enabled cycle instead of running to counter overflow.
    always_comb begin
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            wrap[i]     = cnt[i] >= (div[i] - CNT_W'(1));
            cnt_next[i] = wrap[i] ? '0 : cnt[i] + CNT_W'(1);
            apply[i]    = pending[i] && (wrap[i] || !enable[i]);
            div_next[i] = apply[i] ? shadow[i] : div[i];
        end
    end

`ifdef DIVIDER_SQUARE_EN
    logic [CNT_W-1:0]    half    [CHANNELS];
    logic [CHANNELS-1:0] sq_next;
    logic [CHANNELS-1:0] sq_reg;

    always_comb begin
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            half[i]    = div_next[i] - (div_next[i] >> 1);
            sq_next[i] = cnt_next[i] < half[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sq_reg <= '0;
        end else begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                if (enable[i]) sq_reg[i] <= sq_next[i];
            end
        end
    end

    assign sq_out = sq_reg;
`else
    assign sq_out = '0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                cnt[i]    <= '0;
                div[i]    <= CNT_W'(DEFAULT_DIV);
                shadow[i] <= CNT_W'(DEFAULT_DIV);
            end
            pending   <= '0;
            tick      <= '0;
            cfg_err   <= 1'b0;
            cfg_ready <= 1'b1;
        end else begin
            cfg_ready <= !accept;
            cfg_err   <= accept && !cfg_ok;
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                if (enable[i]) cnt[i] <= cnt_next[i];
                tick[i] <= enable[i] && wrap[i];
                div[i]  <= div_next[i];
                if (apply[i]) pending[i] <= 1'b0;
            end
            // A new write lands after any reload this cycle, so it stays pending.
            if (accept && cfg_ok) begin
                shadow[cfg_chan]  <= cfg_div;
                pending[cfg_chan] <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_multi_clock_divider.sv
// Self-checking bench for multi_clock_divider (3 channels, default ratio 10).
// Square-wave expectations follow whether DIVIDER_SQUARE_EN is defined for the build.
module tb_multi_clock_divider;

    localparam int NCH = 3;
    localparam int DDIV = 10;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [NCH-1:0] enable = '0;
    logic           cfg_valid = 1'b0;
    logic           cfg_ready;
    logic [1:0]     cfg_chan = '0;
    logic [25:0]    cfg_div = '0;
    logic           cfg_err;
    logic [NCH-1:0] tick;
    logic [NCH-1:0] sq_out;

    int checks = 0;
    int errors = 0;

    // Reference model: elapsed enabled cycles since the last tick, per channel.
    int             m_el [NCH];
    int             m_div[NCH];
    int             m_sh [NCH];
    bit             m_pend[NCH];
    logic [NCH-1:0] m_tick;
    logic [NCH-1:0] m_sq;
    logic           m_ready;
    logic           m_err;

    multi_clock_divider #(.CHANNELS(NCH), .CNT_W(26), .DEFAULT_DIV(DDIV)) dut (
        .clk(clk), .reset(reset), .enable(enable), .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready), .cfg_chan(cfg_chan), .cfg_div(cfg_div),
        .cfg_err(cfg_err), .tick(tick), .sq_out(sq_out)
    );

    always #5 clk = ~clk;

    task automatic model_step();
        bit acc, ok;
        if (reset) begin
            for (int i = 0; i < NCH; i++) begin
                m_el[i] = 0; m_div[i] = DDIV; m_sh[i] = DDIV; m_pend[i] = 0;
            end
            m_tick = '0; m_sq = '0; m_ready = 1'b1; m_err = 1'b0;
        end else begin
            acc = cfg_valid && m_ready;
            ok  = (cfg_div != 0) && (cfg_chan < NCH);
            for (int i = 0; i < NCH; i++) begin
                if (enable[i]) begin
                    m_el[i] = m_el[i] + 1;
                    m_tick[i] = (m_el[i] >= m_div[i]);
                    if (m_tick[i]) begin
                        m_el[i] = 0;
                        if (m_pend[i]) begin m_div[i] = m_sh[i]; m_pend[i] = 0; end
                    end
`ifdef DIVIDER_SQUARE_EN
                    m_sq[i] = (m_el[i] < (m_div[i] + 1) / 2);
`endif
                end else begin
                    m_tick[i] = 1'b0;
                    if (m_pend[i]) begin m_div[i] = m_sh[i]; m_pend[i] = 0; end
                end
            end
            m_err   = acc && !ok;
            m_ready = !acc;
            if (acc && ok) begin
                m_sh[cfg_chan]   = int'(cfg_div);
                m_pend[cfg_chan] = 1;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; enable = '0; cfg_valid = 1'b0;
        step(); step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = '1; cfg_valid = 1'b0;
        for (int n = 0; n < 3; n++) begin
            step();
            checks++;
            if ({tick, sq_out, cfg_err, cfg_ready} !== {{(2*NCH+1){1'b0}}, 1'b1}) begin
                errors++;
                $display("FAIL reset_outputs cyc %0d got tick=%b sq=%b err=%b rdy=%b exp 0/0/0/1",
                         n, tick, sq_out, cfg_err, cfg_ready);
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_basic();
        logic [40:0] got, exp_t;
        int sq_high;
        do_reset();
        enable = '1; got = '0; exp_t = '0; sq_high = 0;
        exp_t[10] = 1'b1; exp_t[20] = 1'b1; exp_t[30] = 1'b1;
        for (int s = 1; s <= 30; s++) begin
            step();
            got[s] = tick[0];
            if (s > 20 && sq_out[1]) sq_high++;
            checks++;
            if ({tick, sq_out, cfg_ready, cfg_err} !== {m_tick, m_sq, m_ready, m_err}) begin
                errors++;
                $display("FAIL basic_model s=%0d got %b/%b/%b/%b exp %b/%b/%b/%b", s,
                         tick, sq_out, cfg_ready, cfg_err, m_tick, m_sq, m_ready, m_err);
            end
        end
        checks++;
        if (got !== exp_t) begin
            errors++;
            $display("FAIL basic_tick_positions got %h exp %h", got, exp_t);
        end
`ifdef DIVIDER_SQUARE_EN
        checks++;
        if (sq_high != 5) begin
            errors++;
            $display("FAIL basic_sq_duty got %0d exp 5", sq_high);
        end
`endif
    endtask

    task automatic test_write_ratio();
        logic [40:0] got, exp_t;
        do_reset();
        enable = '1; got = '0; exp_t = '0;
        foreach (exp_t[k]) if (k >= 10 && k <= 31 && (k - 10) % 3 == 0) exp_t[k] = 1'b1;
        for (int s = 1; s <= 31; s++) begin
            cfg_valid = (s == 5); cfg_chan = 2'd1; cfg_div = 26'd3;
            step();
            got[s] = tick[1];
            if (s == 5 || s == 6) begin
                checks++;
                if (cfg_ready !== (s == 6)) begin
                    errors++;
                    $display("FAIL write_ready s=%0d got %b exp %b", s, cfg_ready, s == 6);
                end
            end
            checks++;
            if ({tick, sq_out, cfg_ready, cfg_err} !== {m_tick, m_sq, m_ready, m_err}) begin
                errors++;
                $display("FAIL write_model s=%0d got %b/%b/%b/%b exp %b/%b/%b/%b", s,
                         tick, sq_out, cfg_ready, cfg_err, m_tick, m_sq, m_ready, m_err);
            end
        end
        cfg_valid = 1'b0;
        checks++;
        if (got !== exp_t) begin
            errors++;
            $display("FAIL write_tick_positions got %h exp %h", got, exp_t);
        end
    endtask

    task automatic test_reject();
        logic [40:0] got, exp_t;
        do_reset();
        enable = '1; got = '0; exp_t = '0;
        exp_t[10] = 1'b1; exp_t[20] = 1'b1;
        for (int s = 1; s <= 22; s++) begin
            cfg_valid = (s == 1 || s == 3);
            cfg_chan  = (s == 1) ? 2'd0 : 2'd3;
            cfg_div   = (s == 1) ? 26'd0 : 26'd4;
            step();
            got[s] = tick[0];
            if (s <= 4) begin
                checks++;
                if (cfg_err !== (s == 1 || s == 3)) begin
                    errors++;
                    $display("FAIL reject_err s=%0d got %b exp %b", s, cfg_err, s == 1 || s == 3);
                end
            end
            checks++;
            if ({tick, sq_out, cfg_ready, cfg_err} !== {m_tick, m_sq, m_ready, m_err}) begin
                errors++;
                $display("FAIL reject_model s=%0d got %b/%b/%b/%b exp %b/%b/%b/%b", s,
                         tick, sq_out, cfg_ready, cfg_err, m_tick, m_sq, m_ready, m_err);
            end
        end
        cfg_valid = 1'b0;
        checks++;
        if (got !== exp_t) begin
            errors++;
            $display("FAIL reject_periods got %h exp %h", got, exp_t);
        end
    endtask

    task automatic test_enable_gap();
        logic [40:0] got, exp_t;
        logic held;
        do_reset();
        enable = '1; got = '0; exp_t = '0; held = 1'b0;
        exp_t[17] = 1'b1; exp_t[27] = 1'b1;
        for (int s = 1; s <= 28; s++) begin
            enable = (s >= 5 && s <= 11) ? 3'b011 : 3'b111;
            if (s == 5) held = sq_out[2];
            step();
            got[s] = tick[2];
            if (s >= 5 && s <= 11) begin
                checks++;
                if ({tick[2], sq_out[2]} !== {1'b0, held}) begin
                    errors++;
                    $display("FAIL gap_hold s=%0d got tick=%b sq=%b exp tick=0 sq=%b",
                             s, tick[2], sq_out[2], held);
                end
            end
            checks++;
            if ({tick, sq_out, cfg_ready, cfg_err} !== {m_tick, m_sq, m_ready, m_err}) begin
                errors++;
                $display("FAIL gap_model s=%0d got %b/%b/%b/%b exp %b/%b/%b/%b", s,
                         tick, sq_out, cfg_ready, cfg_err, m_tick, m_sq, m_ready, m_err);
            end
        end
        enable = '1;
        checks++;
        if (got !== exp_t) begin
            errors++;
            $display("FAIL gap_tick_positions got %h exp %h", got, exp_t);
        end
    endtask

    task automatic test_div1_odd();
        int sq_high;
        do_reset();
        enable = '1; sq_high = 0;
        for (int s = 1; s <= 30; s++) begin
            cfg_valid = (s == 1 || s == 3);
            cfg_chan  = (s == 1) ? 2'd0 : 2'd1;
            cfg_div   = (s == 1) ? 26'd1 : 26'd5;
            step();
            if (s >= 11) begin
                if (sq_out[1]) sq_high++;
                checks++;
                if (tick[0] !== 1'b1) begin
                    errors++;
                    $display("FAIL div1_tick s=%0d got %b exp 1", s, tick[0]);
                end
            end
            checks++;
            if ({tick, sq_out, cfg_ready, cfg_err} !== {m_tick, m_sq, m_ready, m_err}) begin
                errors++;
                $display("FAIL div1_model s=%0d got %b/%b/%b/%b exp %b/%b/%b/%b", s,
                         tick, sq_out, cfg_ready, cfg_err, m_tick, m_sq, m_ready, m_err);
            end
        end
        cfg_valid = 1'b0;
`ifdef DIVIDER_SQUARE_EN
        checks++;
        if (sq_high != 12 || sq_out[0] !== 1'b1) begin
            errors++;
            $display("FAIL odd_sq_duty got high=%0d sq0=%b exp high=12 sq0=1", sq_high, sq_out[0]);
        end
`endif
    endtask

    task automatic test_reset_pending();
        logic [40:0] got, exp_t;
        do_reset();
        enable = '1;
        for (int s = 1; s <= 7; s++) begin
            cfg_valid = (s == 7); cfg_chan = 2'd2; cfg_div = 26'd4;
            step();
        end
        cfg_valid = 1'b0; reset = 1'b1;
        step();
        checks++;
        if ({tick, sq_out, cfg_err, cfg_ready} !== {{(2*NCH+1){1'b0}}, 1'b1}) begin
            errors++;
            $display("FAIL midreset_outputs got tick=%b sq=%b err=%b rdy=%b exp 0/0/0/1",
                     tick, sq_out, cfg_err, cfg_ready);
        end
        reset = 1'b0; got = '0; exp_t = '0; exp_t[10] = 1'b1; exp_t[20] = 1'b1;
        for (int s = 1; s <= 20; s++) begin
            step();
            got[s] = tick[2];
            checks++;
            if ({tick, sq_out, cfg_ready, cfg_err} !== {m_tick, m_sq, m_ready, m_err}) begin
                errors++;
                $display("FAIL midreset_model s=%0d got %b/%b/%b/%b exp %b/%b/%b/%b", s,
                         tick, sq_out, cfg_ready, cfg_err, m_tick, m_sq, m_ready, m_err);
            end
        end
        checks++;
        if (got !== exp_t) begin
            errors++;
            $display("FAIL midreset_discard got %h exp %h", got, exp_t);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int s = 0; s < 3000; s++) begin
            reset = ($urandom_range(0, 399) == 0);
            for (int i = 0; i < NCH; i++) enable[i] = ($urandom_range(0, 4) != 0);
            cfg_valid = ($urandom_range(0, 5) == 0);
            cfg_chan  = 2'($urandom_range(0, 3));
            cfg_div   = 26'($urandom_range(0, 12));
            step();
            checks++;
            if ({tick, sq_out, cfg_ready, cfg_err} !== {m_tick, m_sq, m_ready, m_err}) begin
                errors++;
                $display("FAIL random_model s=%0d got %b/%b/%b/%b exp %b/%b/%b/%b", s,
                         tick, sq_out, cfg_ready, cfg_err, m_tick, m_sq, m_ready, m_err);
            end
        end
        reset = 1'b0; cfg_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_write_ratio();
        test_reject();
        test_enable_gap();
        test_div1_odd();
        test_reset_pending();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
